// File: rtl/rah_app_rx_framer.sv
// rah_app_rx_framer: pops one app channel's decoder data queue and re-frames
// the words into a valid/ready payload stream with start/last markers.
// Packet layout: one header word (LEN in bits [15:0]) followed by LEN payload
// words. A 2-entry skid FIFO absorbs the queue's 1-cycle read latency.
module rah_app_rx_framer #(
    parameter int DATA_WIDTH = 48,
    parameter int MAX_LEN    = 4096,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  q_empty,
    input  logic [DATA_WIDTH-1:0] q_rd_data,
    output logic                  q_request,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  err_zero_len,
    output logic                  err_oversize,
    output logic [15:0]           pkt_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_skid [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_cnt;
    logic                  r_inflight;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_first;
    logic                  r_err_zero;
    logic                  r_err_over;
    logic [15:0]           r_pkt_count;
    logic                  r_rst_meta;
    logic                  r_run;

    logic [DATA_WIDTH-1:0] w_head;
    logic [LEN_W-1:0]      w_len;
    logic                  w_nonempty;
    logic                  w_valid;
    logic                  w_pop;
    logic [1:0]            w_occ_after;

    assign w_head     = r_skid[r_rd_ptr];
    assign w_len      = w_head[LEN_W-1:0];
    assign w_nonempty = (r_cnt != 2'd0);
    assign w_valid    = (r_state == S_PAY) && w_nonempty;

    // Headers and dropped words leave the skid unconditionally; payload
    // leaves only on a sink handshake.
    assign w_pop = w_nonempty && ((r_state == S_HDR) || (r_state == S_DROP) ||
                                  ((r_state == S_PAY) && m_ready));

    // Occupancy net of this cycle's pop plus the word still in flight. Using
    // the post-pop figure lets a pop and a request overlap every cycle, so the
    // stream runs at one word per cycle while never exceeding 2 buffered words.
    assign w_occ_after = r_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
    assign q_request   = r_run && !q_empty && (w_occ_after < 2'd2);

    assign m_valid      = w_valid;
    assign m_data       = w_head;
    assign m_sop        = w_valid && r_first;
    assign m_eop        = w_valid && (r_remaining == ONE_C);
    assign err_zero_len = r_err_zero;
    assign err_oversize = r_err_over;
    assign pkt_count    = r_pkt_count;

    // Reset synchronizer: assert asynchronously, release popping two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_run      <= r_rst_meta;
        end
    end

    // Skid FIFO: the word requested last cycle is written now; head pops on w_pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid[0]  <= '0;
            r_skid[1]  <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= q_request;
            if (r_inflight) begin
                r_skid[r_wr_ptr] <= q_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_cnt <= w_occ_after;
        end
    end

    // Framing FSM: parse header, stream or drop the payload, count packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HDR;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_err_zero  <= 1'b0;
            r_err_over  <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            r_err_zero <= 1'b0;
            r_err_over <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_nonempty) begin
                        if (w_len == '0) begin
                            r_err_zero <= 1'b1;
                        end else if (w_len > MAX_LEN_C) begin
                            r_err_over  <= 1'b1;
                            r_remaining <= w_len;
                            r_state     <= S_DROP;
                        end else begin
                            r_remaining <= w_len;
                            r_first     <= 1'b1;
                            r_state     <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (w_valid && m_ready) begin
                        r_remaining <= r_remaining - ONE_C;
                        r_first     <= 1'b0;
                        if (r_remaining == ONE_C) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                            r_state     <= S_HDR;
                        end
                    end
                end
                S_DROP: begin
                    if (w_nonempty) begin
                        r_remaining <= r_remaining - ONE_C;
                        if (r_remaining == ONE_C)
                            r_state <= S_HDR;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_rah_app_rx_framer.sv
// Directed bench for rah_app_rx_framer: a queue model answers pops with
// 1-cycle latency, a monitor captures beats and checks stall stability.
module tb_rah_app_rx_framer;

    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          q_empty;
    logic [DW-1:0] q_rd_data;
    logic          q_request;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sop;
    logic          m_eop;
    logic          err_zero_len;
    logic          err_oversize;
    logic [15:0]   pkt_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q_mem [$];
    logic [DW-1:0] cap_data [$];
    logic          cap_sop [$];
    logic          cap_eop [$];
    int            cap_cyc [$];
    int            cyc = 0;
    int            first_req = -1;
    int            first_val = -1;
    int            n_zero = 0;
    int            n_over = 0;

    rah_app_rx_framer #(.DATA_WIDTH(DW), .MAX_LEN(4096), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_rd_data(q_rd_data),
        .q_request(q_request), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .err_zero_len(err_zero_len),
        .err_oversize(err_oversize), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (cap_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("beat_timeout", 64'(cap_data.size() >= n), 64'(1));
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [DW-1:0] d,
                            input logic s, input logic e);
        if (i < cap_data.size()) begin
            chk({tag, "_data"}, 64'(cap_data[i]), 64'(d));
            chk({tag, "_sop"},  64'(cap_sop[i]),  64'(s));
            chk({tag, "_eop"},  64'(cap_eop[i]),  64'(e));
        end else begin
            chk({tag, "_missing"}, 64'(cap_data.size()), 64'(i + 1));
        end
    endtask

    // Queue model: answers a pop seen at an edge with data shortly after it.
    initial begin
        logic req;
        q_empty   = 1'b1;
        q_rd_data = '0;
        forever begin
            @(posedge clk);
            req = q_request;
            #1;
            if (req && q_mem.size() > 0) q_rd_data = q_mem.pop_front();
            #1;
            q_empty = (q_mem.size() == 0);
        end
    end

    // Monitor: capture beats, count error pulses, check stall stability.
    initial begin
        logic          stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic          ps = 1'b0, pe = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (q_request && first_req < 0) first_req = cyc;
                if (m_valid && first_val < 0) first_val = cyc;
                if (err_zero_len) n_zero++;
                if (err_oversize) n_over++;
                if (stall) begin
                    chk("stall_valid", 64'(m_valid), 64'(1));
                    chk("stall_data",  64'(m_data),  64'(pd));
                    chk("stall_sop",   64'(m_sop),   64'(ps));
                    chk("stall_eop",   64'(m_eop),   64'(pe));
                end
                stall = m_valid && !m_ready;
                pd = m_data; ps = m_sop; pe = m_eop;
                if (m_valid && m_ready) begin
                    cap_data.push_back(m_data);
                    cap_sop.push_back(m_sop);
                    cap_eop.push_back(m_eop);
                    cap_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] w;
        int k;
        rst_n   = 1'b0;
        m_ready = 1'b0;

        // Reset: queue already loaded (header has junk in the ignored upper bits).
        q_mem.push_back(48'hFFFF_FFFF_0003);
        q_mem.push_back(48'hA000_0000_000A);
        q_mem.push_back(48'hB000_0000_000B);
        q_mem.push_back(48'hC000_0000_000C);
        repeat (3) tick();
        chk("rst_q_request", 64'(q_request), 64'(0));
        chk("rst_m_valid",   64'(m_valid),   64'(0));
        chk("rst_m_data",    64'(m_data),    64'(0));
        chk("rst_sop_eop",   64'({m_sop, m_eop}), 64'(0));
        chk("rst_errs",      64'({err_zero_len, err_oversize}), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));

        // 1: back-to-back delivery with m_ready held high.
        m_ready = 1'b1;
        rst_n   = 1'b1;
        wait_beats(3, 40);
        chk_beat("t1_a", 0, 48'hA000_0000_000A, 1'b1, 1'b0);
        chk_beat("t1_b", 1, 48'hB000_0000_000B, 1'b0, 1'b0);
        chk_beat("t1_c", 2, 48'hC000_0000_000C, 1'b0, 1'b1);
        if (cap_cyc.size() >= 3) chk("t1_consecutive", 64'(cap_cyc[2] - cap_cyc[0]), 64'(2));
        chk("t1_latency", 64'(first_val - first_req), 64'(3));
        tick();
        chk("t1_pkt_count", 64'(pkt_count), 64'(1));

        // 2: ready pattern 1,0,0,1,... ; monitor checks stall stability.
        clear_cap();
        q_mem.push_back(48'h0000_0000_0003);
        q_mem.push_back(48'hD000_0000_000D);
        q_mem.push_back(48'hE000_0000_000E);
        q_mem.push_back(48'hF000_0000_000F);
        k = 0;
        while (cap_data.size() < 3 && k < 60) begin
            m_ready = ((k % 3) == 0);
            tick();
            k++;
        end
        m_ready = 1'b1;
        chk("t2_count", 64'(cap_data.size()), 64'(3));
        chk_beat("t2_d", 0, 48'hD000_0000_000D, 1'b1, 1'b0);
        chk_beat("t2_e", 1, 48'hE000_0000_000E, 1'b0, 1'b0);
        chk_beat("t2_f", 2, 48'hF000_0000_000F, 1'b0, 1'b1);
        repeat (3) tick();
        chk("t2_no_extra", 64'(cap_data.size()), 64'(3));
        chk("t2_pkt_count", 64'(pkt_count), 64'(2));

        // 3: LEN=0 header, then a single-word packet.
        clear_cap();
        n_zero = 0;
        q_mem.push_back(48'h1234_0000_0000);
        q_mem.push_back(48'h0000_0000_0001);
        q_mem.push_back(48'h5555_AAAA_5555);
        wait_beats(1, 40);
        repeat (3) tick();
        chk("t3_zero_pulses", 64'(n_zero), 64'(1));
        chk("t3_count", 64'(cap_data.size()), 64'(1));
        chk_beat("t3_x", 0, 48'h5555_AAAA_5555, 1'b1, 1'b1);
        chk("t3_pkt_count", 64'(pkt_count), 64'(3));

        // 4: oversize packet dropped with m_ready low, then a LEN=2 packet.
        clear_cap();
        n_over = 0;
        m_ready = 1'b0;
        q_mem.push_back(48'h0000_0000_1001);
        for (int i = 0; i < 4097; i++) begin
            w = 48'h0000_0001_0000 | 48'(i);
            q_mem.push_back(w);
        end
        q_mem.push_back(48'h0000_0000_0002);
        q_mem.push_back(48'h0000_0000_0BEE);
        q_mem.push_back(48'h0000_0000_0CEE);
        k = 0;
        while (q_mem.size() > 0 && k < 6000) begin
            tick();
            k++;
        end
        chk("t4_drain_timeout", 64'(q_mem.size()), 64'(0));
        repeat (4) tick();
        chk("t4_over_pulses", 64'(n_over), 64'(1));
        chk("t4_none_emitted", 64'(cap_data.size()), 64'(0));
        chk("t4_p_waiting", 64'({m_valid, m_sop, m_eop}), 64'(3'b110));
        chk("t4_p_data", 64'(m_data), 64'(48'h0000_0000_0BEE));
        m_ready = 1'b1;
        wait_beats(2, 20);
        chk_beat("t4_p", 0, 48'h0000_0000_0BEE, 1'b1, 1'b0);
        chk_beat("t4_q", 1, 48'h0000_0000_0CEE, 1'b0, 1'b1);
        tick();
        chk("t4_pkt_count", 64'(pkt_count), 64'(4));

        // 5: queue runs dry after word 2 of a LEN=4 packet.
        clear_cap();
        q_mem.push_back(48'h0000_0000_0004);
        q_mem.push_back(48'h0000_0000_1111);
        q_mem.push_back(48'h0000_0000_2222);
        wait_beats(2, 40);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_gap_valid", 64'(m_valid), 64'(0));
        end
        q_mem.push_back(48'h0000_0000_3333);
        q_mem.push_back(48'h0000_0000_4444);
        wait_beats(4, 40);
        chk_beat("t5_w1", 0, 48'h0000_0000_1111, 1'b1, 1'b0);
        chk_beat("t5_w2", 1, 48'h0000_0000_2222, 1'b0, 1'b0);
        chk_beat("t5_w3", 2, 48'h0000_0000_3333, 1'b0, 1'b0);
        chk_beat("t5_w4", 3, 48'h0000_0000_4444, 1'b0, 1'b1);
        tick();
        chk("t5_pkt_count", 64'(pkt_count), 64'(5));

        // 6: reset while word 2 of a LEN=5 packet is stalled on the output.
        clear_cap();
        q_mem.push_back(48'h0000_0000_0005);
        q_mem.push_back(48'h0000_0000_0551);
        q_mem.push_back(48'h0000_0000_0552);
        q_mem.push_back(48'h0000_0000_0553);
        wait_beats(1, 40);
        m_ready = 1'b0;
        repeat (2) tick();
        chk("t6_word2_shown", 64'({m_valid, m_data}), 64'({1'b1, 48'h0000_0000_0552}));
        rst_n = 1'b0;
        q_mem.delete();
        #1;
        chk("t6_rst_outputs", 64'({m_valid, m_sop, m_eop, q_request}), 64'(0));
        chk("t6_rst_data", 64'(m_data), 64'(0));
        chk("t6_rst_pkt_count", 64'(pkt_count), 64'(0));
        repeat (2) tick();
        clear_cap();
        q_mem.push_back(48'h0000_0000_0001);
        q_mem.push_back(48'h0000_0000_0777);
        m_ready = 1'b1;
        rst_n   = 1'b1;
        wait_beats(1, 40);
        repeat (2) tick();
        chk("t6_count", 64'(cap_data.size()), 64'(1));
        chk_beat("t6_z", 0, 48'h0000_0000_0777, 1'b1, 1'b1);
        chk("t6_pkt_count", 64'(pkt_count), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
